// File: rtl/acuity_chart_display.sv
// acuity_chart_display -- tumbling-E visual-acuity tester (top level).
// Shows an E optotype on an 8x8 LED matrix and the acuity on a 2-digit 7-seg.
// A staircase FSM steps through the level table from the four direction keys.
// Optional feature macro: ACUITY_TIMEOUT_EN. When it is defined, an unanswered
// optotype counts as wrong after TIMEOUT_CYC cycles.
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   KeyRESTART            start/restart, active-high
//   KeyLeft/Right/Down/up direction answers, active-high
//   col_pin[7:0]          matrix columns, active-high
//   row_pin[7:0]          matrix rows, active-low one-hot scan
//   seg_sel[7:0]          digit select, active-low (bits 1:0 used)
//   seg_led[7:0]          segments {dp,g,f,e,d,c,b,a}, active-low
//   tem1[3:0], tem2[3:0]  debug: level index, FSM state code
module acuity_chart_display #(
   parameter int unsigned SCAN_DIV = 16,
   parameter int unsigned SEG_DIV  = 32
`ifdef ACUITY_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 1000000
`endif
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       KeyRESTART,
   input  logic       KeyLeft,
   input  logic       KeyRight,
   input  logic       KeyDown,
   input  logic       Keyup,
   output logic [7:0] col_pin,
   output logic [7:0] row_pin,
   output logic [7:0] seg_sel,
   output logic [7:0] seg_led,
   output logic [3:0] tem1,
   output logic [3:0] tem2
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FIRST = 3'd1, DESC = 3'd2, ASC = 3'd3, DONE_PASS = 3'd4, DONE_FAIL = 3'd5
   } state_t;

   localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned SGW = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [SGW-1:0] SEG_LAST  = SGW'(SEG_DIV - 1);

   // Direction codes: 0 right, 1 left, 2 up, 3 down.
   function automatic logic [1:0] target_dir(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1: return 2'd2;
         3'd3:       return 2'd0;
         default:    return 2'd3;
      endcase
   endfunction

   // One pixel of the E for level idx at matrix row r, column c.
   function automatic logic glyph_px(input logic [2:0] idx, input logic [2:0] r, input logic [2:0] c);
      logic [3:0] sz, off, mid, last, y, x;
      logic       in_box, px;
      sz     = (idx < 3'd2) ? 4'd7 : (idx < 3'd4) ? 4'd5 : 4'd3;
      off    = (4'd8 - sz) >> 1;
      mid    = sz >> 1;
      last   = sz - 4'd1;
      y      = {1'b0, r} - off;
      x      = {1'b0, c} - off;
      in_box = ({1'b0, r} >= off) && ({1'b0, c} >= off) && (y < sz) && (x < sz);
      case (target_dir(idx))
         2'd0:    px = (x == 4'd0) || (y == 4'd0) || (y == mid) || (y == last);
         2'd1:    px = (x == last) || (y == 4'd0) || (y == mid) || (y == last);
         2'd2:    px = (y == last) || (x == 4'd0) || (x == mid) || (x == last);
         default: px = (y == 4'd0) || (x == 4'd0) || (x == mid) || (x == last);
      endcase
      return in_box && px;
   endfunction

   // Active-high {g,f,e,d,c,b,a} pattern for a decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;
         4'd8: return 7'h7F;  default: return 7'h00;
      endcase
   endfunction

   function automatic logic [3:0] tenth_of(input logic [2:0] idx);
      case (idx)
         3'd0: return 4'd1;  3'd1: return 4'd2;  3'd2: return 4'd4;  3'd3: return 4'd6;
         3'd4: return 4'd8;  3'd5: return 4'd0;  3'd6: return 4'd2;  default: return 4'd5;
      endcase
   endfunction

   state_t         state_q, state_d;
   logic [2:0]     level_q, level_d;
   logic [4:0]     key_q, key_prev_q, key_edge;
   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]     row_q, row_d;
   logic [SGW-1:0] seg_cnt_q, seg_cnt_d;
   logic           digit_q, digit_d;
   logic [7:0]     col_q, col_d, rowp_q, rowp_d, sel_q, sel_d, led_q, led_d;
   logic [7:0]     row_bits;
   logic [3:0]     dir_e;
   logic           active, answer, ans_valid, ans_ok, tmo_hit;

   // key_q bits: {restart, down, up, left, right}; low four match direction codes.
   assign key_edge = key_q & ~key_prev_q;
   assign dir_e    = key_edge[3:0];
   assign active   = (state_q == FIRST) || (state_q == DESC) || (state_q == ASC);
   assign answer   = active && !key_edge[4] && (dir_e != 4'd0) && ((dir_e & (dir_e - 4'd1)) == 4'd0);

`ifdef ACUITY_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   always_comb begin
      tmo_hit = active && !answer && !key_edge[4] && (tmo_q == 32'(TIMEOUT_CYC - 1));
      tmo_d   = tmo_q + 32'd1;
      if (!active || answer || key_edge[4] || tmo_hit) tmo_d = '0;
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign ans_valid = answer || tmo_hit;
   assign ans_ok    = answer && dir_e[target_dir(level_q)];

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (key_edge[4]) begin
         state_d = FIRST;
         level_d = 3'd4;
      end else if (ans_valid) begin
         case (state_q)
            FIRST: begin
               state_d = ans_ok ? ASC : DESC;
               level_d = ans_ok ? level_q + 3'd1 : level_q - 3'd1;
            end
            DESC: begin
               if (ans_ok)                state_d = DONE_PASS;
               else if (level_q != 3'd0)  level_d = level_q - 3'd1;
               else                       state_d = DONE_FAIL;
            end
            ASC: begin
               if (!ans_ok) begin
                  state_d = DONE_PASS;
                  level_d = level_q - 3'd1;
               end else if (level_q != 3'd7) level_d = level_q + 3'd1;
               else                           state_d = DONE_PASS;
            end
            default: ;
         endcase
      end
      if (state_d == DONE_FAIL) level_d = '0;
   end

   always_comb begin
      for (int unsigned c = 0; c < 8; c++) begin
         case (state_q)
            FIRST, DESC, ASC: row_bits[3'(c)] = glyph_px(level_q, row_q, 3'(c));
            DONE_FAIL:        row_bits[3'(c)] = (3'(c) == row_q) || (3'(c) == (3'd7 - row_q));
            default:          row_bits[3'(c)] = 1'b0;
         endcase
      end
      // Row outputs are reloaded only at the start of a slot so a pattern
      // change never tears a row part-way through its display time.
      scan_cnt_d = scan_cnt_q + 1'b1;
      row_d      = row_q;
      col_d      = col_q;
      rowp_d     = rowp_q;
      if (scan_cnt_q == '0) begin
         col_d  = row_bits;
         rowp_d = ~(8'h01 << row_q);
      end
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         row_d      = row_q + 3'd1;
      end

      seg_cnt_d = seg_cnt_q + 1'b1;
      digit_d   = digit_q;
      if (seg_cnt_q == SEG_LAST) begin
         seg_cnt_d = '0;
         digit_d   = ~digit_q;
      end
      sel_d = digit_q ? 8'hFD : 8'hFE;
      if (digit_q) led_d = ~{1'b1, seg7((level_q >= 3'd5) ? 4'd1 : 4'd0)};
      else         led_d = ~{1'b0, seg7(tenth_of(level_q))};
      if (state_q == IDLE) begin
         sel_d = 8'hFF;
         led_d = 8'hFF;
      end else if (state_q == DONE_FAIL) begin
         led_d = 8'hBF;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         level_q    <= 3'd4;
         key_q      <= '0;
         key_prev_q <= '0;
         scan_cnt_q <= '0;
         row_q      <= '0;
         seg_cnt_q  <= '0;
         digit_q    <= 1'b0;
         col_q      <= '0;
         rowp_q     <= '1;
         sel_q      <= '1;
         led_q      <= '1;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         key_q      <= {KeyRESTART, KeyDown, Keyup, KeyLeft, KeyRight};
         key_prev_q <= key_q;
         scan_cnt_q <= scan_cnt_d;
         row_q      <= row_d;
         seg_cnt_q  <= seg_cnt_d;
         digit_q    <= digit_d;
         col_q      <= col_d;
         rowp_q     <= rowp_d;
         sel_q      <= sel_d;
         led_q      <= led_d;
      end
   end

   assign col_pin = col_q;
   assign row_pin = rowp_q;
   assign seg_sel = sel_q;
   assign seg_led = led_q;
   assign tem1    = {1'b0, level_q};
   assign tem2    = {1'b0, state_q};
endmodule

// File: tb/tb_acuity_chart_display.sv
// tb_acuity_chart_display -- directed self-checking bench for acuity_chart_display.
// Key vector order used by press(): {restart, down, up, left, right}.
module tb_acuity_chart_display;
   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       KeyRESTART = 1'b0, KeyLeft = 1'b0, KeyRight = 1'b0, KeyDown = 1'b0, Keyup = 1'b0;
   logic [7:0] col_pin, row_pin, seg_sel, seg_led;
   logic [3:0] tem1, tem2;
   int         n_checks = 0;
   int         n_errors = 0;

   localparam logic [4:0] K_R = 5'b00001, K_L = 5'b00010, K_U = 5'b00100, K_D = 5'b01000, K_RS = 5'b10000;

   acuity_chart_display #(.SCAN_DIV(16), .SEG_DIV(32)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .KeyRESTART(KeyRESTART), .KeyLeft(KeyLeft),
      .KeyRight(KeyRight), .KeyDown(KeyDown), .Keyup(Keyup), .col_pin(col_pin),
      .row_pin(row_pin), .seg_sel(seg_sel), .seg_led(seg_led), .tem1(tem1), .tem2(tem2));

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic press(input logic [4:0] k, input int hold);
      {KeyRESTART, KeyDown, Keyup, KeyLeft, KeyRight} = k;
      tick(hold);
      {KeyRESTART, KeyDown, Keyup, KeyLeft, KeyRight} = '0;
      tick(4);
   endtask

   // Wait for a fresh slot of row r, then compare its column pattern.
   task automatic check_row(input string tag, input int r, input logic [7:0] exp_col);
      logic [7:0] tgt;
      int         n;
      tgt = ~(8'h01 << r);
      n = 0;
      while (row_pin == tgt && n < 200) begin tick(1); n++; end
      while (row_pin != tgt && n < 400) begin tick(1); n++; end
      if (row_pin != tgt) chk({tag, "_timeout"}, {24'h0, row_pin}, {24'h0, tgt});
      else                chk(tag, {24'h0, col_pin}, {24'h0, exp_col});
   endtask

   task automatic check_seg(input string tag, input logic [7:0] sel, input logic [7:0] exp_led);
      int n;
      n = 0;
      while (seg_sel != sel && n < 100) begin tick(1); n++; end
      if (seg_sel != sel) chk({tag, "_timeout"}, {24'h0, seg_sel}, {24'h0, sel});
      else                chk(tag, {24'h0, seg_led}, {24'h0, exp_led});
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_col"}, {24'h0, col_pin}, 32'h00);
      chk({tag, "_row"}, {24'h0, row_pin}, 32'hFF);
      chk({tag, "_sel"}, {24'h0, seg_sel}, 32'hFF);
      chk({tag, "_led"}, {24'h0, seg_led}, 32'hFF);
      chk({tag, "_tem1"}, {28'h0, tem1}, 32'd4);
      chk({tag, "_tem2"}, {28'h0, tem2}, 32'd0);
   endtask

   initial begin
      tick(3);
      check_reset_vals("rst");
      sys_rst = 1'b0;
      tick(5);
      chk("idle_tem2", {28'h0, tem2}, 32'd0);
      chk("idle_sel", {24'h0, seg_sel}, 32'hFF);
      press(K_L, 2);
      chk("idle_key_ignored", {28'h0, tem1}, 32'd4);

      // 1: descend to failure
      press(K_RS, 2);
      chk("t1_first", {28'h0, tem2}, 32'd1);
      check_seg("t1_d1_08", 8'hFD, 8'h40);
      check_seg("t1_d0_08", 8'hFE, 8'h80);
      check_row("t1_row0_idx4", 0, 8'h00);
      check_row("t1_row2_idx4", 2, 8'h1C);
      press(K_L, 20);
      chk("t1_held_once", {28'h0, tem1}, 32'd3);
      chk("t1_desc", {28'h0, tem2}, 32'd2);
      check_row("t1_row1_idx3", 1, 8'h3E);
      check_row("t1_row2_idx3", 2, 8'h02);
      press(K_L, 2);
      chk("t1_idx2", {28'h0, tem1}, 32'd2);
      press(K_R, 2);
      chk("t1_idx1", {28'h0, tem1}, 32'd1);
      press(K_R, 2);
      chk("t1_idx0", {28'h0, tem1}, 32'd0);
      press(K_R, 2);
      chk("t1_fail_tem2", {28'h0, tem2}, 32'd5);
      chk("t1_fail_tem1", {28'h0, tem1}, 32'd0);
      check_row("t1_x_row0", 0, 8'h81);
      check_row("t1_x_row3", 3, 8'h18);
      check_seg("t1_dash1", 8'hFD, 8'hBF);
      check_seg("t1_dash0", 8'hFE, 8'hBF);

      // 2: descend then pass at 0.4
      press(K_RS, 2);
      press(K_L, 2);
      press(K_L, 2);
      chk("t2_idx2", {28'h0, tem1}, 32'd2);
      press(K_D, 2);
      chk("t2_pass_tem2", {28'h0, tem2}, 32'd4);
      chk("t2_pass_tem1", {28'h0, tem1}, 32'd2);
      check_seg("t2_d1", 8'hFD, 8'h40);
      check_seg("t2_d0", 8'hFE, 8'h99);

      // 3: climb to the top
      press(K_RS, 2);
      press(K_D, 2);
      chk("t3_asc", {28'h0, tem2}, 32'd3);
      press(K_D, 2);
      press(K_D, 2);
      chk("t3_idx7", {28'h0, tem1}, 32'd7);
      press(K_D, 2);
      chk("t3_pass_tem2", {28'h0, tem2}, 32'd4);
      chk("t3_pass_tem1", {28'h0, tem1}, 32'd7);
      check_seg("t3_d1", 8'hFD, 8'h79);
      check_seg("t3_d0", 8'hFE, 8'h92);
      check_row("t3_blank_row3", 3, 8'h00);
      press(K_L, 2);
      chk("t3_done_ignores", {28'h0, tem1}, 32'd7);

      // 4: wrong answer while ascending
      press(K_RS | K_D, 2);
      chk("t4_restart_prio", {28'h0, tem1}, 32'd4);
      chk("t4_restart_state", {28'h0, tem2}, 32'd1);
      press(K_D, 2);
      press(K_D, 2);
      chk("t4_idx6", {28'h0, tem1}, 32'd6);
      press(K_U, 2);
      chk("t4_pass_tem2", {28'h0, tem2}, 32'd4);
      chk("t4_pass_tem1", {28'h0, tem1}, 32'd5);
      check_seg("t4_d1", 8'hFD, 8'h79);
      check_seg("t4_d0", 8'hFE, 8'hC0);

      // 5: reset mid-test
      press(K_RS, 2);
      press(K_L, 2);
      sys_rst = 1'b1;
      tick(1);
      check_reset_vals("t5");
      sys_rst = 1'b0;
      press(K_D, 2);
      chk("t5_key_ignored_tem2", {28'h0, tem2}, 32'd0);
      chk("t5_key_ignored_tem1", {28'h0, tem1}, 32'd4);

      // 6: simultaneous directions ignored; row scan order
      press(K_RS, 2);
      press(K_L | K_D, 2);
      chk("t6_multi_tem1", {28'h0, tem1}, 32'd4);
      chk("t6_multi_tem2", {28'h0, tem2}, 32'd1);
      check_row("t6_sync", 0, 8'h00);
      tick(8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t6_row%0d", k), {24'h0, row_pin}, {24'h0, ~(8'h01 << k)});
         tick(16);
      end
      chk("t6_wrap", {24'h0, row_pin}, 32'hFE);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
